// File: rtl/nibble_pack_fifo.sv
// Packs a 4-bit sample stream into 32-bit words (first nibble in the LSBs) and
// buffers them in a first-word-fall-through FIFO with level and sticky overflow.
module nibble_pack_fifo #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [3:0]        NIB_DATA,
  input  logic              NIB_VALID,
  input  logic              ENABLE,
  input  logic              CLEAR,
  input  logic              RD_EN,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic [ADDR_W:0]   LEVEL,
  output logic              FULL,
  output logic              OVERFLOW
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [2:0]        nib_cnt_q, nib_cnt_d;
  logic [27:0]       part_q, part_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       mem_q [DEPTH];

  logic              accept, complete, push, pop;
  logic [ADDR_W:0]   level;
  logic [31:0]       word;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign FULL     = (level == FULL_LVL);
  assign RD_VALID = (level != '0);
  assign LEVEL    = level;
  assign OVERFLOW = ovf_q;
  assign RD_DATA  = RD_VALID ? mem_q[rd_ptr_q[ADDR_W-1:0]] : 32'h0;

  assign accept   = NIB_VALID & ENABLE & ~CLEAR;
  assign complete = accept & (nib_cnt_q == 3'd7);
  assign word     = {NIB_DATA, part_q};
  assign pop      = RD_EN & RD_VALID & ~CLEAR;
  // A pop in the same cycle frees the slot a full FIFO needs for the new word.
  assign push     = complete & (~FULL | pop);

  always_comb begin
    nib_cnt_d = nib_cnt_q;
    part_d    = part_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    if (CLEAR) begin
      nib_cnt_d = '0;
      part_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ovf_d     = 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          nib_cnt_d = '0;
          part_d    = '0;
        end else begin
          nib_cnt_d = nib_cnt_q + 3'd1;
          for (int k = 0; k < 7; k++)
            if (nib_cnt_q == 3'(k)) part_d[4*k +: 4] = NIB_DATA;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (complete && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      nib_cnt_q <= '0;
      part_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      nib_cnt_q <= nib_cnt_d;
      part_q    <= part_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; RD_DATA is masked while the FIFO is empty.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= word;
  end

endmodule

// File: doc/nibble_pack_fifo.md
# nibble_pack_fifo

Packs the 4-bit LVDS sample stream, already captured and resynchronised into the AXI clock domain, into 32-bit words. Buffers those words in a first-word-fall-through FIFO that `data_read` drains through its AXI-lite read path. The block sits directly upstream of the `data_read` register file. It provides word data, fill level and a sticky overflow flag, which that file exposes to software.

## Interface

Parameters:
- `DEPTH`, default 256: FIFO depth in 32-bit words. Must be a power of two, ≥ 4.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width. Derived; do not override.

Ports:
- `S_AXI_ACLK`  in  1: sole clock. All logic is on the rising edge.
- `S_AXI_ARESETN`  in  1: asynchronous, active-low reset.
- `NIB_DATA`  in  4: sample nibble, qualified by `NIB_VALID`.
- `NIB_VALID`  in  1: one nibble offered this cycle. There is no backpressure.
- `ENABLE`  in  1: capture enable. Nibbles are ignored while low.
- `CLEAR`  in  1: synchronous flush, one-cycle pulse or level.
- `RD_EN`  in  1: pop the head word. Ignored when `RD_VALID`=0.
- `RD_DATA`  out  32: head word. Forced to 0 while `RD_VALID`=0.
- `RD_VALID`  out  1: FIFO non-empty.
- `LEVEL`  out  `ADDR_W`+1: words stored, 0..`DEPTH`.
- `FULL`  out  1: `LEVEL`==`DEPTH`.
- `OVERFLOW`  out  1: sticky. Set when a completed word is dropped.

## Operation

Nibble packer:
- 3-bit nibble counter `nib_cnt` plus a 28-bit partial register.
- Accept a nibble when `NIB_VALID`=1, `ENABLE`=1 and `CLEAR`=0.
- Nibble k (k=0..7) lands in word bits [4k+3:4k]. First nibble is LSB.
- The 8th accepted nibble (`nib_cnt`=7) completes the word as {`NIB_DATA`, partial[27:0]}, issues a write request, and wraps `nib_cnt` to 0.
- `ENABLE` low holds the partial word and `nib_cnt` unchanged. Capture resumes where it stopped.

FIFO:
- `DEPTH` words.
- `wr_ptr` and `rd_ptr` are `ADDR_W`+1 bits wide and wrap modulo 2·`DEPTH`.
- `LEVEL` = `wr_ptr` − `rd_ptr`.
- Write accepted if `FULL`=0, or if `FULL`=1 and a pop occurs the same cycle. The pop frees the slot.
- Write rejected (`FULL`=1, no pop): the word is discarded, `OVERFLOW` is set, and `nib_cnt` still wraps to 0 so word alignment is preserved.
- Pop = `RD_EN` & `RD_VALID`. A pop advances `rd_ptr`.
- Push and pop in the same cycle leave `LEVEL` unchanged.
- `OVERFLOW` is cleared only by `CLEAR` or reset.

`CLEAR` has priority over all other events in its cycle. It zeroes the pointers, `nib_cnt`, the partial word and `OVERFLOW`. A nibble or `RD_EN` in the same cycle is discarded.

Reset (asynchronous, `S_AXI_ARESETN`=0) has the same effect as `CLEAR`. Outputs take these values: `RD_VALID`=0, `RD_DATA`=0, `LEVEL`=0, `FULL`=0, `OVERFLOW`=0. Memory contents are don't-care.

## Timing

- The completing nibble is sampled at edge N. `LEVEL`, `FULL`, `RD_VALID` and `RD_DATA` update after edge N.
- Nibble-to-readable latency is 1 cycle.
- First-word fall-through: `RD_DATA` shows the head word combinationally from the registered `rd_ptr`, with no read latency.
- A pop at edge M presents the next word, or 0 with `RD_VALID`=0, after edge M.
- Full input rate is supported: `NIB_VALID` may be high every cycle, giving one word per 8 cycles.
- `RD_EN` may be high every cycle.
- All outputs are registered, or derived from registered pointers. There are no combinational paths from inputs to outputs.
- Back-to-back reads with `LEVEL`=1 and a word completing in the same cycle: the pop takes the old head, and the new word becomes head after the edge.

## Test plan

- **Reset/idle:** hold reset 20 cycles, release with no stimulus -> `RD_VALID`=0, `RD_DATA`=0, `LEVEL`=0, `OVERFLOW`=0.
- **Packing order:** nibbles 1,2,...,8 on consecutive cycles -> one cycle after the 8th, `RD_VALID`=1, `RD_DATA`=0x87654321 and `LEVEL`=1; `RD_EN` pulse -> `RD_VALID`=0, `LEVEL`=0.
- **Enable gap:** nibbles 0xA,0xB,0xC; `ENABLE` low 10 cycles with `NIB_VALID`=1, `NIB_DATA`=0xF; then 0xD,0xE,0x1,0x2,0x3 with `ENABLE` high -> `RD_DATA`=0x321EDCBA, `LEVEL`=1.
- **Fill/overflow:** with `DEPTH`=4, write 5 words with no reads -> `FULL`=1, `LEVEL`=4 and `OVERFLOW`=1 after the 5th word. Reads return words 1..4 only. The 6th word written after draining reads back correctly aligned.
- **Full + simultaneous pop:** `DEPTH`=4 full; word 5 completes in the same cycle as `RD_EN` -> `OVERFLOW` stays 0, `LEVEL` stays 4, and the read order is words 2,3,4,5.
- **Clear mid-word:** 3 nibbles pushed, `LEVEL`=2, `OVERFLOW`=1; assert `CLEAR` with `NIB_VALID`=1 -> next cycle `LEVEL`=0, `OVERFLOW`=0, `RD_VALID`=0. The next 8 nibbles 0x0..0x7 yield 0x76543210.
